// File: rtl/gol_pkg.sv
//==============================================================================
// Module  : gol_pkg
// Brief   : Pad-ring bit map and B3/S23 rule constants for the GoL cell.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package gol_pkg;

    localparam int unsigned BIT_NEIGHBORS_LSB = 9;
    localparam int unsigned BIT_CLK           = 17;
    localparam int unsigned BIT_SET           = 18;
    localparam int unsigned BIT_RESET         = 19;
    localparam int unsigned BIT_ALIVE         = 20;
    localparam int unsigned BIT_NOTALIVE      = 21;

    localparam logic [3:0] BIRTH_COUNT   = 4'd3;
    localparam logic [3:0] SURVIVE_COUNT = 4'd2;

endpackage

`default_nettype wire

// File: rtl/gol_cell.sv
//==============================================================================
// Module  : gol_cell
// Brief   : Single Game-of-Life cell: neighbour popcount and B3/S23 update.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gol_cell
    import gol_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [7:0] neighbors,
    output logic       alive
);

    logic       r_alive;
    logic [3:0] w_count;
    logic       w_next;

    always_comb begin
        w_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + 4'(neighbors[i]);
        end
        w_next = (w_count == BIRTH_COUNT) ||
                 (r_alive && (w_count == SURVIVE_COUNT));
    end

    // reset and set are checked first so unknown neighbours cannot leak in
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alive <= 1'b0;
        end else if (set) begin
            r_alive <= 1'b1;
        end else begin
            r_alive <= w_next;
        end
    end

    assign alive = r_alive;

endmodule

`default_nettype wire

// File: rtl/tiny_user_project.sv
//==============================================================================
// Module  : tiny_user_project
// Brief   : Pad-ring wrapper mapping io_in/io_out/io_oeb onto one gol_cell.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tiny_user_project
    import gol_pkg::*;
#(
    parameter int IO_WIDTH = 38
) (
`ifdef USE_POWER_PINS
    inout  wire                 vccd1,
    inout  wire                 vssd1,
`endif
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb
);

    logic w_alive;

    // Bits outside the cell's map are deliberately left unconnected
    logic w_unused;
    assign w_unused = &{1'b0, io_in[BIT_NEIGHBORS_LSB-1:0],
                        io_in[IO_WIDTH-1:BIT_RESET+1]};

    gol_cell u_cell (
        .clk       (io_in[BIT_CLK]),
        .reset     (io_in[BIT_RESET]),
        .set       (io_in[BIT_SET]),
        .neighbors (io_in[BIT_NEIGHBORS_LSB +: 8]),
        .alive     (w_alive)
    );

    always_comb begin
        io_out               = '0;
        io_out[BIT_ALIVE]    = w_alive;
        io_out[BIT_NOTALIVE] = ~w_alive;

        io_oeb               = '1;
        io_oeb[BIT_ALIVE]    = 1'b0;
        io_oeb[BIT_NOTALIVE] = 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_tiny_user_project.sv
//==============================================================================
// Module  : tb_tiny_user_project
// Brief   : Directed-vector scoreboard bench for the GoL tiny user project.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tiny_user_project;

    localparam int IO_WIDTH = 38;

    logic                clk;
    logic                reset;
    logic                set;
    logic [7:0]          nbrs;
    logic [8:0]          junk_lo;
    logic [17:0]         junk_hi;
    logic [IO_WIDTH-1:0] io_in;
    logic [IO_WIDTH-1:0] io_out;
    logic [IO_WIDTH-1:0] io_oeb;

    logic [IO_WIDTH-1:0] exp_oeb;
    logic [IO_WIDTH-1:0] out_mask;

    int  n_checks;
    int  n_pass;
    bit  exp_q[$];

    assign io_in = {junk_hi, reset, set, clk, nbrs, junk_lo};

    tiny_user_project #(.IO_WIDTH(IO_WIDTH)) dut (
`ifdef USE_POWER_PINS
        .vccd1  (),
        .vssd1  (),
`endif
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: one expected state per clock edge that had stimulus
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            n_checks++;
            if (io_out[20] === e) n_pass++;
            else $display("FAIL alive: got %b want %b (t=%0t)", io_out[20], e, $time);
            n_checks++;
            if (io_out[21] === ~e) n_pass++;
            else $display("FAIL notalive: got %b want %b (t=%0t)", io_out[21], ~e, $time);
            n_checks++;
            if (io_oeb === exp_oeb) n_pass++;
            else $display("FAIL io_oeb: got %h want %h", io_oeb, exp_oeb);
            n_checks++;
            if ((io_out & out_mask) === '0) n_pass++;
            else $display("FAIL io_out_const: got %h want 0", io_out & out_mask);
        end
    end

    task automatic step(input logic r, input logic s, input logic [7:0] nb, input bit e);
        @(negedge clk);
        reset   = r;
        set     = s;
        nb      = nb;
        nbrs    = nb;
        junk_lo = 9'($urandom);
        junk_hi = 18'($urandom);
        exp_q.push_back(e);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_oeb  = ~(38'h3 << 20);
        out_mask = ~(38'h3 << 20);
        reset    = 1'b0;
        set      = 1'b0;
        nbrs     = 8'h00;
        junk_lo  = 9'h1FF;
        junk_hi  = 18'h3FFFF;

        // reset with all neighbours alive
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        // set, then reset and set together
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        // birth from dead with three; no birth with two
        step(1'b0, 1'b0, 8'b0000_0111, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'b0000_0011, 1'b0);
        // survival with two and three
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'b1000_0001, 1'b1);
        step(1'b0, 1'b0, 8'b0001_0101, 1'b1);
        // deaths from alive: 1, 0, 4, 8 neighbours
        step(1'b0, 1'b0, 8'b0000_0001, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'b0000_0000, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'b0000_1111, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'hFF, 1'b0);
        // dead stays dead with four; birth again after death
        step(1'b0, 1'b0, 8'b1111_0000, 1'b0);
        step(1'b0, 1'b0, 8'b1010_1000, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
